// File: rtl/sata_axil_pkg.sv
// Shared types and constants for the SATA AXI4-Lite command master.
`timescale 1ns/1ps
package sata_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/sata_axil_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Optional non-OKAY response counter under SATA_AXIL_ERR_CNT_EN.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready high
// ST_WR      | AW and W presented, each drops on its own handshake
// ST_WR_RESP | BREADY high, waiting for BVALID
// ST_RD_ADDR | ARVALID high, waiting for ARREADY
// ST_RD_DATA | RREADY high, waiting for RVALID
// ST_RSP     | result held on rsp_* until rsp_ready
`timescale 1ns/1ps
module sata_axil_master
  import sata_axil_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 5,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESET,

  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,

  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,

  output logic [ERR_CNT_WIDTH-1:0]    err_count
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic                      write_q, write_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI_RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          rdata_d   = '0;
          resp_d    = AXI_RESP_OKAY;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        // The two handshakes may land in either order or together.
        if (M_AXI_AWREADY) aw_done_d = 1'b1;
        if (M_AXI_WREADY)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          state_d = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates cmd_ready so every ready output reads 0 while reset is held.
  assign cmd_ready     = (state_q == ST_IDLE) && !M_AXI_ARESET;
  assign rsp_valid     = (state_q == ST_RSP);
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = (state_q == ST_WR) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == ST_WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = (state_q == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_RD_DATA);

`ifdef SATA_AXIL_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                     err_hit;

  assign err_hit = ((state_q == ST_WR_RESP) && M_AXI_BVALID && (M_AXI_BRESP != AXI_RESP_OKAY)) ||
                   ((state_q == ST_RD_DATA) && M_AXI_RVALID && (M_AXI_RRESP != AXI_RESP_OKAY));

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
